// File: rtl/latency_pkg.sv
// ---------------------------------------------------------------------------
// latency_pkg
// Shared definitions for the latency average reader:
//   - state_t   : reader FSM states (IDLE, DIV, DONE)
//   - DEF_W     : default counter width
//   - DEF_FRAC  : default number of fractional result bits
//   - result_w  : width of the fixed-point average (W + FRAC)
// ---------------------------------------------------------------------------
package latency_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_W    = 32;
    localparam int DEF_FRAC = 4;

    function automatic int result_w(input int w, input int frac);
        return w + frac;
    endfunction

endpackage

// File: rtl/latency_avg_reader_if.sv
// ---------------------------------------------------------------------------
// latency_avg_reader_if
// Bundles every non-clock/reset signal of the latency average reader.
//   req              request a read (sampled only while idle)
//   issue_cnt_r      issue count from the latency block (W bits)
//   aggregate_cnt_r  aggregate outstanding-cycle count (W bits)
//   clear            one-cycle clear pulse back to the latency block
//   busy             reader is not idle
//   avg_valid        average result valid
//   avg_ready        consumer accepts the result
//   avg_q            average latency, unsigned Q(W).(FRAC)
//   div_zero         snapshot issue count was zero (qualified by avg_valid)
// Modports:
//   slave  - the reader itself
//   master - the requester / consumer / latency block side
// ---------------------------------------------------------------------------
interface latency_avg_reader_if
    import latency_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter int FRAC = DEF_FRAC
) ();

    localparam int RW = result_w(W, FRAC);

    logic          req;
    logic [W-1:0]  issue_cnt_r;
    logic [W-1:0]  aggregate_cnt_r;
    logic          clear;
    logic          busy;
    logic          avg_valid;
    logic          avg_ready;
    logic [RW-1:0] avg_q;
    logic          div_zero;

    modport slave (
        input  req,
        input  issue_cnt_r,
        input  aggregate_cnt_r,
        input  avg_ready,
        output clear,
        output busy,
        output avg_valid,
        output avg_q,
        output div_zero
    );

    modport master (
        output req,
        output issue_cnt_r,
        output aggregate_cnt_r,
        output avg_ready,
        input  clear,
        input  busy,
        input  avg_valid,
        input  avg_q,
        input  div_zero
    );

endinterface

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Multi-cycle unsigned restoring divider, one quotient bit per cycle, MSB
// first. A start pulse loads the operands and runs W+FRAC iterations.
// Ports:
//   clk       clock
//   rst       asynchronous reset, active-low
//   start     load dividend/divisor and begin dividing
//   dividend  W+FRAC bit dividend
//   divisor   W bit divisor
//   done      high during the cycle whose edge completes the last iteration
//   quotient  final quotient; valid only while done is high
// A zero divisor is not special-cased here: every bit comes out as 1 and the
// caller decides what to report.
// ---------------------------------------------------------------------------
module seq_divider
    import latency_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter int FRAC = DEF_FRAC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [W+FRAC-1:0]   dividend,
    input  logic [W-1:0]        divisor,
    output logic                done,
    output logic [W+FRAC-1:0]   quotient
);

    localparam int RW    = result_w(W, FRAC);
    localparam int CNT_W = $clog2(RW + 1);

    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     rem;
    logic [W-1:0]     dvs;
    // Dividend bits shift out of the top while quotient bits shift in at the
    // bottom; after RW iterations the register holds the whole quotient.
    logic [RW-1:0]    dq;

    logic [W:0]       partial;
    logic             q_bit;
    logic [W-1:0]     rem_sub;

    always_comb begin
        partial = {rem, dq[RW-1]};
        q_bit   = (partial >= {1'b0, dvs});
        // When q_bit is set the true difference is below dvs, so it fits in
        // W bits and the modulo-2^W subtraction is exact.
        rem_sub = partial[W-1:0] - dvs;
    end

    assign done     = (cnt == CNT_W'(1));
    assign quotient = {dq[RW-2:0], q_bit};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            rem <= '0;
            dvs <= '0;
            dq  <= '0;
        end else if (start) begin
            cnt <= CNT_W'(RW);
            rem <= '0;
            dvs <= divisor;
            dq  <= dividend;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
            // A clear q_bit means partial < dvs, so its top bit is zero.
            rem <= q_bit ? rem_sub : partial[W-1:0];
            dq  <= {dq[RW-2:0], q_bit};
        end
    end

endmodule

// File: rtl/latency_avg_reader.sv
// ---------------------------------------------------------------------------
// latency_avg_reader
// Reader side of the latency counter interface. On an accepted request it
// snapshots issue_cnt_r and aggregate_cnt_r, divides aggregate by issue with
// a sequential restoring divider and presents the average as an unsigned
// Q(W).(FRAC) value on a valid/ready handshake.
// Ports:
//   clk  clock
//   rst  asynchronous reset, active-low
//   bus  latency_avg_reader_if.slave (req, counters, clear, busy,
//        avg_valid/avg_ready/avg_q, div_zero)
// Optional feature (macro LATENCY_AVG_AUTO_CLEAR_EN):
//   defined   - clear pulses for the one cycle after request acceptance so
//               every read covers a fresh measurement window
//   undefined - clear is tied low and the counters accumulate across reads
// Timing: req accepted at the end of cycle 0 gives avg_valid in cycle
// W+FRAC+1, independent of the data.
// ---------------------------------------------------------------------------
module latency_avg_reader
    import latency_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter int FRAC = DEF_FRAC
) (
    input  logic                   clk,
    input  logic                   rst,
    latency_avg_reader_if.slave    bus
);

    localparam int RW = result_w(W, FRAC);

    state_t        state_q;
    state_t        state_d;
    logic          start;
    logic          busy_c;
    logic          valid_c;
    logic          div_done;
    logic [RW-1:0] quotient;
    logic [RW-1:0] avg_q_q;
    logic          div_zero_q;

    seq_divider #(
        .W    (W),
        .FRAC (FRAC)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend ({bus.aggregate_cnt_r, {FRAC{1'b0}}}),
        .divisor  (bus.issue_cnt_r),
        .done     (div_done),
        .quotient (quotient)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Requests outside IDLE (including one coinciding with the DONE
    // handshake) are dropped, never queued.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        busy_c  = 1'b1;
        valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                busy_c = 1'b0;
                if (bus.req) begin
                    start   = 1'b1;
                    state_d = DIV;
                end
            end
            DIV: begin
                if (div_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                valid_c = 1'b1;
                if (bus.avg_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result registers: only written at acceptance and at the end of the
    // division, so they stay stable under backpressure and keep their value
    // after the handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            avg_q_q    <= '0;
            div_zero_q <= 1'b0;
        end else begin
            if (start) begin
                div_zero_q <= (bus.issue_cnt_r == '0);
            end
            if ((state_q == DIV) && div_done) begin
                avg_q_q <= div_zero_q ? '0 : quotient;
            end
        end
    end

`ifdef LATENCY_AVG_AUTO_CLEAR_EN
    logic clear_q;

    // Registered from acceptance so the clear lands in the cycle after the
    // snapshot edge; events in the acceptance cycle are already captured.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clear_q <= 1'b0;
        end else begin
            clear_q <= start;
        end
    end

    assign bus.clear = clear_q;
`else
    assign bus.clear = 1'b0;
`endif

    assign bus.busy      = busy_c;
    assign bus.avg_valid = valid_c;
    assign bus.avg_q     = avg_q_q;
    assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_latency_avg_reader.sv
// ---------------------------------------------------------------------------
// tb_latency_avg_reader
// Directed bench for latency_avg_reader at W=8, FRAC=4 (12-bit result).
// Cycle n below means n rising edges after the edge that accepts req.
// ---------------------------------------------------------------------------
module tb_latency_avg_reader;

    localparam int W    = 8;
    localparam int FRAC = 4;

`ifdef LATENCY_AVG_AUTO_CLEAR_EN
    localparam logic CLR1 = 1'b1;
`else
    localparam logic CLR1 = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    latency_avg_reader_if #(.W(W), .FRAC(FRAC)) bus ();

    latency_avg_reader #(.W(W), .FRAC(FRAC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full read starting in an IDLE cycle. hold = cycles of backpressure
    // after avg_valid rises; during them the counters change and req pulses.
    task automatic do_read(input logic [7:0] iss, input logic [7:0] agg,
                           input int exp_q, input logic exp_dz,
                           input string tag, input int hold);
        bus.issue_cnt_r     = iss;
        bus.aggregate_cnt_r = agg;
        bus.req             = 1'b1;
        bus.avg_ready       = 1'b0;
        chk({tag, "_busy_c0"}, 32'(bus.busy), 32'd0);
        tick();
        // cycle 1: counters move on; the result must come from the snapshot
        bus.req             = 1'b0;
        bus.issue_cnt_r     = ~iss;
        bus.aggregate_cnt_r = ~agg;
        chk({tag, "_busy_c1"}, 32'(bus.busy), 32'd1);
        chk({tag, "_clear_c1"}, 32'(bus.clear), 32'(CLR1));
        chk({tag, "_valid_c1"}, 32'(bus.avg_valid), 32'd0);
        tick();
        chk({tag, "_clear_c2"}, 32'(bus.clear), 32'd0);
        for (int c = 3; c <= 12; c++) tick();
        chk({tag, "_valid_c12"}, 32'(bus.avg_valid), 32'd0);
        chk({tag, "_busy_c12"}, 32'(bus.busy), 32'd1);
        tick();
        chk({tag, "_valid_c13"}, 32'(bus.avg_valid), 32'd1);
        chk({tag, "_q"}, 32'(bus.avg_q), 32'(exp_q));
        chk({tag, "_dz"}, 32'(bus.div_zero), 32'(exp_dz));
        chk({tag, "_busy_c13"}, 32'(bus.busy), 32'd1);
        for (int h = 0; h < hold; h++) begin
            bus.issue_cnt_r     = 8'd7 + 8'(h);
            bus.aggregate_cnt_r = 8'd3;
            bus.req             = (h % 2 == 0);
            tick();
            chk({tag, "_bp_valid"}, 32'(bus.avg_valid), 32'd1);
            chk({tag, "_bp_q"}, 32'(bus.avg_q), 32'(exp_q));
            chk({tag, "_bp_dz"}, 32'(bus.div_zero), 32'(exp_dz));
        end
        // handshake cycle; with backpressure, also raise req to show it is dropped
        bus.req       = (hold > 0);
        bus.avg_ready = 1'b1;
        tick();
        bus.req       = 1'b0;
        bus.avg_ready = 1'b0;
        chk({tag, "_valid_after"}, 32'(bus.avg_valid), 32'd0);
        chk({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
        chk({tag, "_q_kept"}, 32'(bus.avg_q), 32'(exp_q));
        tick();
        chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_idle_clear"}, 32'(bus.clear), 32'd0);
    endtask

    initial begin
        checks              = 0;
        errors              = 0;
        rst                 = 1'b0;
        bus.req             = 1'b0;
        bus.avg_ready       = 1'b0;
        bus.issue_cnt_r     = '0;
        bus.aggregate_cnt_r = '0;
        #2;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_valid", 32'(bus.avg_valid), 32'd0);
        chk("rst_clear", 32'(bus.clear), 32'd0);
        chk("rst_q", 32'(bus.avg_q), 32'd0);
        chk("rst_dz", 32'(bus.div_zero), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        do_read(8'd4,   8'd50,  200,  1'b0, "avg12p5", 0);
        do_read(8'd0,   8'd17,  0,    1'b1, "divzero", 0);
        do_read(8'd1,   8'd255, 4080, 1'b0, "maxq",    0);
        do_read(8'd255, 8'd1,   0,    1'b0, "minq",    0);
        do_read(8'd7,   8'd3,   6,    1'b0, "frac7",   0);
        do_read(8'd3,   8'd10,  53,   1'b0, "frac3",   0);
        do_read(8'd5,   8'd100, 320,  1'b0, "backpr",  5);

        // Asynchronous reset in cycle 6 of a division
        bus.issue_cnt_r     = 8'd9;
        bus.aggregate_cnt_r = 8'd90;
        bus.req             = 1'b1;
        tick();
        bus.req = 1'b0;
        for (int c = 2; c <= 6; c++) tick();
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.avg_valid), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_clear", 32'(bus.clear), 32'd0);
        chk("mid_rst_q", 32'(bus.avg_q), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        do_read(8'd3, 8'd30, 160, 1'b0, "after_rst", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/latency_avg_reader.md
Name: latency_avg_reader

Overview:
Reader side of the latency counter interface. On request it snapshots the `issue_cnt_r` and `aggregate_cnt_r` outputs of the latency block. It then computes average latency (aggregate/issue) as an unsigned fixed-point value using a multi-cycle restoring divider. The result is presented on a valid/ready handshake. Optionally, it pulses the latency block's `clear` input so each read covers a fresh measurement window.

Parameters:
- W, 32, width of the issue and aggregate counters being read.
- FRAC, 4, fractional bits of the average; the result is W+FRAC bits, formatted as unsigned Q(W).(FRAC).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- req  in  1  request a read; sampled only in IDLE.
- issue_cnt_r  in  W  issue count from the latency block.
- aggregate_cnt_r  in  W  aggregate outstanding-cycle count from the latency block.
- clear  out  1  one-cycle clear pulse to the latency block.
- busy  out  1  high in any state other than IDLE.
- avg_valid  out  1  result valid.
- avg_ready  in  1  consumer accepts the result.
- avg_q  out  W+FRAC  average latency, fixed point.
- div_zero  out  1  snapshot issue count was 0; qualified by avg_valid.

Behaviour:
- Reset values: state IDLE; clear, busy, avg_valid, div_zero = 0; avg_q = 0; internal registers = 0.
- FSM: IDLE -> DIV -> DONE -> IDLE.
- IDLE:
  - Edge with req=1: capture dividend = {aggregate_cnt_r, FRAC'b0} and divisor = issue_cnt_r.
  - Set the iteration counter to W+FRAC and go to DIV.
  - Set div_zero = (issue_cnt_r == 0).
- DIV:
  - Restoring division, one quotient bit per cycle, MSB first.
  - Partial remainder is W+1 bits; quotient is W+FRAC bits.
  - When the counter reaches 0, go to DONE and assert avg_valid.
- Latency:
  - req high in cycle 0 gives avg_valid high in cycle W+FRAC+1 (37 cycles at defaults).
  - Timing is fixed and data-independent.
- Zero divisor: DIV still runs the full W+FRAC cycles; the quotient is forced to 0 and div_zero=1.
- No overflow: the quotient is at most aggregate*2^FRAC < 2^(W+FRAC), so no saturation is needed.
- DONE:
  - avg_q and div_zero are held stable while avg_valid=1 and avg_ready=0.
  - On an edge with avg_valid & avg_ready: deassert avg_valid, go to IDLE.
  - avg_q keeps its last value after the handshake.
- Request handling:
  - req in DIV or DONE is ignored and not queued.
  - req in the same cycle as the DONE handshake is ignored; it must be held or re-asserted in IDLE.
- Asynchronous reset mid-operation: immediate return to IDLE with reset values; the in-flight result is discarded.
- Input sampling: inputs are sampled only at acceptance; later counter changes do not affect the result.

Optional Feature:
- Macro: LATENCY_AVG_AUTO_CLEAR_EN.
- Defined:
  - clear=1 for exactly the one cycle after the req-acceptance edge (cycle 1).
  - This resets the latency counters once the snapshot is taken.
  - Events landing in cycle 0 are counted in this snapshot; events from cycle 1 are lost with the clear.
- Undefined: clear is tied to 0 and counters accumulate across reads.

Decomposition:
- Package latency_pkg:
  - FSM state enum (IDLE, DIV, DONE).
  - Default W and FRAC localparams.
  - Helper function giving the result width (W+FRAC).
- Sub-module seq_divider:
  - Parameterised restoring divider.
  - Ports: start, dividend, divisor, done, quotient.
  - Holds the iteration counter and remainder.
  - latency_avg_reader holds the FSM, snapshot, handshake and clear logic.

Test Plan (W=8, FRAC=4, result 12 bits):
- issue=4, agg=50, req pulse cycle 0 -> avg_valid rises cycle 13, avg_q=200 (12.5), div_zero=0, busy 1 in cycles 1..13.
- issue=0, agg=17 -> avg_valid at cycle 13, avg_q=0, div_zero=1.
- issue=1, agg=255 -> avg_q=4080 (max, no wrap); issue=255, agg=1 -> avg_q=0.
- Backpressure: avg_ready=0 for 5 cycles after valid; change counter inputs and pulse req meanwhile -> avg_q, div_zero stable; no second result; handshake returns to IDLE.
- Reset (rst=0) at cycle 6 of DIV -> avg_valid, busy, clear = 0 immediately; next req with issue=3, agg=30 -> avg_q=160.
- With LATENCY_AVG_AUTO_CLEAR_EN: clear high exactly in cycle 1 after each acceptance. Without it: clear stays 0 for the whole test.
